// File: rtl/dmem_block_mover_pkg.sv
// Shared definitions for the data-memory block mover.
// Holds the FSM state encoding, the command mode constants and the memory depth.
package dmem_block_mover_pkg;

  localparam int MEM_DEPTH = 128;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } moverState_t;

endpackage

// File: rtl/dmem_block_mover_addr_seq.sv
// dmem_addr_seq: word-index sequencer for one side (source or destination)
// of a block move.
//   clk, rst_n : clock, async active-low reset (index clears to 0)
//   load       : take loadVal as the new index (has priority over step)
//   loadVal    : start index of the block
//   step       : advance the index by one word
//   down       : step direction, 1 = decrement
//   idxNext    : the index the register will hold after this edge
// Stepping wraps naturally modulo 2^ADDR_W.
module dmem_addr_seq
  import dmem_block_mover_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] loadVal,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] idxNext
);

  logic [ADDR_W-1:0] idx;

  // The owner registers its memory address from idxNext so that the
  // address appears in the same cycle the new index becomes current.
  always_comb begin
    idxNext = idx;
    if (load) begin
      idxNext = loadVal;
    end else if (step) begin
      idxNext = down ? (idx - ADDR_W'(1)) : (idx + ADDR_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else begin
      idx <= idxNext;
    end
  end

endmodule

// File: rtl/dmem_block_mover.sv
// dmem_block_mover: bus initiator that copies (memmove semantics) or fills a
// block of the 128x32 data memory while the CPU is held off via busy.
//   clk, rst_n          : clock, async active-low reset
//   start               : command strobe, only looked at in IDLE
//   mode                : 0 = copy, 1 = fill
//   src_addr, dst_addr  : start word addresses (src ignored for fill)
//   length              : word count, 0..128 legal
//   fill_value          : word written in fill mode
//   mem_addr/_wdata     : registered memory address and write data
//   mem_write/_read     : registered memory enables (never both high)
//   mem_rdata           : combinational read data from the memory
//   busy, done, err     : status; done and err are one-cycle pulses
//
// state | meaning
// IDLE  | waiting for start; rejects length>128 with err
// RD    | read one source word, capture it into the buffer
// WR    | write one destination word, step indices, count down
// FIN   | enables off, done pulse, back to IDLE
//
// Every output is a register loaded with the value that belongs to the
// state being entered, so the outputs always match the current state.
module dmem_block_mover
  import dmem_block_mover_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [7:0]        length,
  input  logic [DATA_W-1:0] fill_value,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  moverState_t state, stateNext;

  logic              modeQ, modeNext;
  logic              descQ, descNext;
  logic [DATA_W-1:0] fillQ, fillNext;
  logic [DATA_W-1:0] bufQ, bufNext;
  logic [7:0]        remQ, remNext;

  logic [ADDR_W-1:0] addrNext;
  logic [DATA_W-1:0] wdataNext;
  logic              writeNext, readNext, busyNext, doneNext, errNext;

  logic              seqLoad, seqStep;
  logic [ADDR_W-1:0] srcIdxNext, dstIdxNext;

  logic [ADDR_W-1:0] delta;
  logic [7:0]        lenM1;
  logic              descCmd;
  logic [ADDR_W-1:0] srcStart, dstStart;

  // A copy whose destination lies ahead of the source inside the block
  // would overwrite unread source words, so it runs from the top down.
  always_comb begin
    delta    = dst_addr - src_addr;
    lenM1    = length - 8'd1;
    descCmd  = (mode == MODE_COPY) && (delta != '0) && (16'(delta) < 16'(length));
    srcStart = descCmd ? (src_addr + ADDR_W'(lenM1)) : src_addr;
    dstStart = descCmd ? (dst_addr + ADDR_W'(lenM1)) : dst_addr;
  end

  dmem_addr_seq #(.ADDR_W(ADDR_W)) uSrcSeq (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (seqLoad),
    .loadVal (srcStart),
    .step    (seqStep),
    .down    (descQ),
    .idxNext (srcIdxNext)
  );

  dmem_addr_seq #(.ADDR_W(ADDR_W)) uDstSeq (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (seqLoad),
    .loadVal (dstStart),
    .step    (seqStep),
    .down    (descQ),
    .idxNext (dstIdxNext)
  );

  always_comb begin
    stateNext = state;
    modeNext  = modeQ;
    descNext  = descQ;
    fillNext  = fillQ;
    bufNext   = bufQ;
    remNext   = remQ;
    seqLoad   = 1'b0;
    seqStep   = 1'b0;
    addrNext  = mem_addr;
    wdataNext = mem_wdata;
    writeNext = 1'b0;
    readNext  = 1'b0;
    busyNext  = 1'b0;
    doneNext  = 1'b0;
    errNext   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          if (int'(length) > MEM_DEPTH) begin
            errNext = 1'b1;
          end else if (length == 8'd0) begin
            stateNext = ST_FIN;
          end else begin
            modeNext  = mode;
            descNext  = descCmd;
            fillNext  = fill_value;
            remNext   = length;
            seqLoad   = 1'b1;
            stateNext = (mode == MODE_COPY) ? ST_RD : ST_WR;
          end
        end
      end
      ST_RD: begin
        bufNext   = mem_rdata;
        stateNext = ST_WR;
      end
      ST_WR: begin
        seqStep = 1'b1;
        remNext = remQ - 8'd1;
        if (remQ == 8'd1) begin
          stateNext = ST_FIN;
        end else begin
          stateNext = (modeQ == MODE_COPY) ? ST_RD : ST_WR;
        end
      end
      ST_FIN: begin
        stateNext = ST_IDLE;
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase

    // Outputs for the state being entered.
    case (stateNext)
      ST_RD: begin
        busyNext = 1'b1;
        readNext = 1'b1;
        addrNext = srcIdxNext;
      end
      ST_WR: begin
        busyNext  = 1'b1;
        writeNext = 1'b1;
        addrNext  = dstIdxNext;
        wdataNext = (modeNext == MODE_FILL) ? fillNext : bufNext;
      end
      ST_FIN: begin
        doneNext = 1'b1;
      end
      default: begin
        busyNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      modeQ     <= MODE_COPY;
      descQ     <= 1'b0;
      fillQ     <= '0;
      bufQ      <= '0;
      remQ      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= stateNext;
      modeQ     <= modeNext;
      descQ     <= descNext;
      fillQ     <= fillNext;
      bufQ      <= bufNext;
      remQ      <= remNext;
      mem_addr  <= addrNext;
      mem_wdata <= wdataNext;
      mem_write <= writeNext;
      mem_read  <= readNext;
      busy      <= busyNext;
      done      <= doneNext;
      err       <= errNext;
    end
  end

endmodule

// File: tb/tb_dmem_block_mover.sv
// Bench for dmem_block_mover: a 128x32 memory with a combinational read
// path, a reference memory updated with plain memmove/fill arithmetic,
// a table of directed commands, hand-written busy/reset sequences and a
// randomized command loop.
module tb_dmem_block_mover;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [6:0]  src_addr = '0;
  logic [6:0]  dst_addr = '0;
  logic [7:0]  length = '0;
  logic [31:0] fill_value = '0;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        err;

  dmem_block_mover #(.ADDR_W(7), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .fill_value (fill_value),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  logic [31:0] tbMem   [128];
  logic [31:0] loadImg [128];
  logic [31:0] refMem  [128];
  logic        loadReq = 1'b0;

  always @(posedge clk) begin
    if (loadReq) tbMem <= loadImg;
    else if (mem_write) tbMem[mem_addr] <= mem_wdata;
  end

  assign mem_rdata = mem_read ? tbMem[mem_addr] : 32'hDEAD_BEEF;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic memCheck(input string name);
    int bad = -1;
    for (int i = 0; i < 128; i++) if (bad < 0 && tbMem[i] !== refMem[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: word %0d got %0h expected %0h", name, bad, tbMem[bad], refMem[bad]);
    end
  endtask

  // Reference: a copy reads the whole source block before writing anything.
  function automatic void modelApply(input bit m, input int s, input int d, input int l, input logic [31:0] f);
    logic [31:0] tmp [128];
    if (l > 128) return;
    for (int i = 0; i < l; i++) tmp[i] = refMem[(s + i) % 128];
    for (int i = 0; i < l; i++) refMem[(d + i) % 128] = m ? f : tmp[i];
  endfunction

  task automatic preload();
    @(negedge clk);
    loadImg = refMem;
    loadReq = 1'b1;
    @(negedge clk);
    loadReq = 1'b0;
  endtask

  // Issues one command and watches it until done/err or a cycle budget.
  // Cycle 0 is the first cycle after the accepting edge.
  task automatic runCmd(input bit m, input int s, input int d, input int l, input logic [31:0] f,
                        input int intrudeAt,
                        output int writes, output int reads, output int both, output int doneCyc,
                        output int firstWrAddr, output int firstWrCyc, output bit gotErr,
                        output bit gotDone, output int busySeen);
    writes = 0; reads = 0; both = 0; doneCyc = -1; firstWrAddr = -1; firstWrCyc = -1;
    gotErr = 0; gotDone = 0; busySeen = 0;
    @(negedge clk);
    mode = m; src_addr = 7'(s); dst_addr = 7'(d); length = 8'(l); fill_value = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == intrudeAt) begin
        start = 1'b1; mode = ~m; length = 8'd200; dst_addr = 7'd100;
      end else begin
        start = 1'b0;
      end
      if (mem_write) begin
        if (firstWrCyc < 0) begin
          firstWrCyc = cyc;
          firstWrAddr = int'(mem_addr);
        end
        writes++;
      end
      if (mem_read) reads++;
      if (mem_read && mem_write) both++;
      if (busy) busySeen++;
      if (err) begin gotErr = 1; break; end
      if (done) begin gotDone = 1; doneCyc = cyc; break; end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  typedef struct {
    bit          m;
    int          src;
    int          dst;
    int          len;
    logic [31:0] fill;
    bit          expErr;
    bit          expDone;
    int          expWr;
    int          expRd;
    int          expCyc;
    int          expFirst;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wr, rd, bo, dc, fa, fc, bs;
    bit ge, gd;
    int sawDone;

    // expCyc: fill finishes at cycle len, copy at 2*len; err never finishes.
    vecs[0]  = '{1'b1,   0,  10,   4, 32'hA5A5A5A5, 1'b0, 1'b1,   4, 0,   4,  10};
    vecs[1]  = '{1'b0,  20,  40,   3, 32'h0,        1'b0, 1'b1,   3, 3,   6,  40};
    vecs[2]  = '{1'b0,   0,   1,   4, 32'h0,        1'b0, 1'b1,   4, 4,   8,   4};
    vecs[3]  = '{1'b1,   0, 126,   4, 32'h7,        1'b0, 1'b1,   4, 0,   4, 126};
    vecs[4]  = '{1'b0,  30,  60,   0, 32'h0,        1'b0, 1'b1,   0, 0,   0,  -1};
    vecs[5]  = '{1'b1,   0,  70, 129, 32'h55,       1'b1, 1'b0,   0, 0,  -1,  -1};
    vecs[6]  = '{1'b0,   5,   5,   3, 32'h0,        1'b0, 1'b1,   3, 3,   6,   5};
    vecs[7]  = '{1'b0,   1,   0,   4, 32'h0,        1'b0, 1'b1,   4, 4,   8,   0};
    vecs[8]  = '{1'b0, 120,   2,  10, 32'h0,        1'b0, 1'b1,  10, 10, 20,   2};
    vecs[9]  = '{1'b0, 125, 126,   5, 32'h0,        1'b0, 1'b1,   5, 5,  10,   2};
    vecs[10] = '{1'b0,   9,   9, 255, 32'h0,        1'b1, 1'b0,   0, 0,  -1,  -1};
    vecs[11] = '{1'b1,   0,   0, 128, 32'h12345678, 1'b0, 1'b1, 128, 0, 128,   0};

    #1;
    check("reset_outputs", {mem_addr, mem_wdata, mem_write, mem_read, busy, done, err}, 64'd0);

    for (int i = 0; i < 128; i++) refMem[i] = $urandom;
    for (int i = 0; i < 3; i++) refMem[20 + i] = 32'(i + 1);
    for (int i = 0; i < 4; i++) refMem[i] = 32'(i + 1);
    preload();
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 12; v++) begin
      runCmd(vecs[v].m, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].fill, -1,
             wr, rd, bo, dc, fa, fc, ge, gd, bs);
      modelApply(vecs[v].m, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].fill);
      check($sformatf("v%0d_err", v), 64'(ge), 64'(vecs[v].expErr));
      check($sformatf("v%0d_done", v), 64'(gd), 64'(vecs[v].expDone));
      check($sformatf("v%0d_writes", v), 64'(wr), 64'(vecs[v].expWr));
      check($sformatf("v%0d_reads", v), 64'(rd), 64'(vecs[v].expRd));
      check($sformatf("v%0d_rd_wr_overlap", v), 64'(bo), 64'd0);
      check($sformatf("v%0d_done_cycle", v), 64'(dc), 64'(vecs[v].expCyc));
      check($sformatf("v%0d_first_wr_addr", v), 64'(fa), 64'(vecs[v].expFirst));
      if (vecs[v].expErr) check($sformatf("v%0d_busy_on_err", v), 64'(bs), 64'd0);
      if (vecs[v].expWr > 0)
        check($sformatf("v%0d_first_wr_cycle", v), 64'(fc), 64'(vecs[v].m ? 0 : 1));
      memCheck($sformatf("v%0d_mem", v));
    end

    // start while busy: a would-be err command mid-fill must be ignored.
    runCmd(1'b1, 0, 60, 6, 32'hBEEF0001, 2, wr, rd, bo, dc, fa, fc, ge, gd, bs);
    modelApply(1'b1, 0, 60, 6, 32'hBEEF0001);
    check("busy_start_err", 64'(ge), 64'd0);
    check("busy_start_writes", 64'(wr), 64'd6);
    check("busy_start_done_cycle", 64'(dc), 64'd6);
    check("busy_start_busy_cycles", 64'(bs), 64'd6);
    memCheck("busy_start_mem");
    @(negedge clk);
    check("busy_start_no_late_err", 64'(err), 64'd0);

    // Reset in the middle of a fill of 50..57, after three writes.
    @(negedge clk);
    mode = 1'b1; dst_addr = 7'd50; length = 8'd8; fill_value = 32'hCAFE0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr = 0;
    sawDone = 0;
    for (int c = 0; c < 20 && wr < 3; c++) begin
      if (mem_write) wr++;
      if (done) sawDone++;
      if (wr < 3) @(negedge clk);
    end
    check("rst_mid_pre_writes", 64'(wr), 64'd3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {mem_addr, mem_wdata, mem_write, mem_read, busy, done, err}, 64'd0);
    repeat (3) begin
      @(negedge clk);
      if (done) sawDone++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done) sawDone++;
    end
    check("rst_mid_no_done", 64'(sawDone), 64'd0);
    check("rst_mid_idle_busy", 64'(busy), 64'd0);
    for (int i = 50; i < 53; i++) refMem[i] = 32'hCAFE0001;
    memCheck("rst_mid_mem");

    // Randomized commands against the reference memory.
    for (int i = 0; i < 128; i++) refMem[i] = $urandom;
    preload();
    for (int n = 0; n < 30; n++) begin
      bit m;
      int s, d, l, dl, expFirst;
      logic [31:0] f;
      bit isErr, isDesc;
      m = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: l = $urandom_range(129, 255);
        1: l = 128;
        2: l = 0;
        default: l = $urandom_range(1, 24);
      endcase
      f = $urandom;
      s = $urandom_range(0, 127);
      d = $urandom_range(0, 127);
      // memmove on a ring is only well defined without overlap at both ends
      for (int t = 0; t < 50; t++) begin
        dl = (d - s + 128) % 128;
        if (m || l > 128 || dl == 0 || dl >= l || (128 - dl) >= l) break;
        s = $urandom_range(0, 127);
        d = $urandom_range(0, 127);
      end
      dl = (d - s + 128) % 128;
      if (!m && l <= 128 && dl != 0 && dl < l && (128 - dl) < l) d = s;
      dl = (d - s + 128) % 128;
      isErr = (l > 128);
      isDesc = !m && dl != 0 && dl < l;
      expFirst = (isErr || l == 0) ? -1 : (isDesc ? (d + l - 1) % 128 : d);
      runCmd(m, s, d, l, f, -1, wr, rd, bo, dc, fa, fc, ge, gd, bs);
      modelApply(m, s, d, l, f);
      check($sformatf("r%0d_err", n), 64'(ge), 64'(isErr));
      check($sformatf("r%0d_done", n), 64'(gd), 64'(!isErr));
      check($sformatf("r%0d_writes", n), 64'(wr), 64'(isErr ? 0 : l));
      check($sformatf("r%0d_reads", n), 64'(rd), 64'((isErr || m) ? 0 : l));
      check($sformatf("r%0d_overlap", n), 64'(bo), 64'd0);
      check($sformatf("r%0d_done_cycle", n), 64'(dc), 64'(isErr ? -1 : (m ? l : 2 * l)));
      check($sformatf("r%0d_first_wr", n), 64'(fa), 64'(expFirst));
      memCheck($sformatf("r%0d_mem", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_block_mover.md
Name: dmem_block_mover

Overview:
- Bus initiator for the 128x32 data memory. It drives the memory's address, write-data, write-enable and read-enable inputs to perform block copy (memmove semantics) and block fill without CPU involvement.
- The memory it drives has a combinational read path: read data is valid in the same cycle as address plus read-enable. Writes commit on the rising clock edge when write-enable is high.
- Sits beside the CPU's memory stage. The top level muxes memory ports to this block whenever busy=1.

Parameters:
- ADDR_W, 7, word-address width (memory depth 2^ADDR_W = 128)
- DATA_W, 32, data word width

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill
- src_addr  in  ADDR_W  copy source start word address (ignored in fill)
- dst_addr  in  ADDR_W  destination start word address
- length  in  8  word count, legal range 0..128
- fill_value  in  DATA_W  word written in fill mode
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_write  out  1  memory write enable
- mem_read  out  1  memory read enable
- mem_rdata  in  DATA_W  memory read data (combinational)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse on completion
- err  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset (async assert): state=IDLE; mem_addr=0, mem_wdata=0, mem_write=0, mem_read=0, busy=0, done=0, err=0; counters and buffer cleared.
- All outputs are registered. mem_* change only on clock edges.
- States: IDLE, RD, WR, FIN.
- In IDLE, start=1 latches all command inputs:
  - length>128: pulse err next cycle, stay IDLE, no memory access.
  - length==0: go to FIN (done pulse, no access).
  - otherwise: busy=1, remaining=length, then copy -> RD, fill -> WR.
- Direction (copy only):
  - Compute delta = (dst - src) mod 128.
  - If delta != 0 and delta < length: descending. Start indices are src+length-1 and dst+length-1, and they decrement.
  - Else: ascending, starting at src and dst, incrementing.
  - Fill is always ascending.
- RD (copy):
  - Drive mem_addr=src_idx, mem_read=1, mem_write=0.
  - At the end of the cycle, capture mem_rdata into the buffer, then go to WR.
- WR:
  - Drive mem_addr=dst_idx, mem_wdata=buffer (copy) or fill_value (fill), mem_write=1, mem_read=0.
  - At the edge, decrement remaining and step the indices.
  - remaining becomes 0 -> FIN. Otherwise copy -> RD, fill -> WR.
- Throughput: copy takes 2 cycles/word, fill takes 1 cycle/word.
- FIN: deassert all mem_* enables, done=1 for one cycle, busy=0, go to IDLE.
- Never assert mem_read and mem_write in the same cycle.
- Address arithmetic is modulo 128, so 127+1 wraps to 0 and 0-1 wraps to 127.
- length==128 is legal and touches every word once.
- start while busy is ignored: no err, no latch.
- Reset mid-operation aborts immediately. Words already written stay written. No done pulse.
- src==dst copy: ascending, and rewrites identical data.

Decomposition:
- Shared package holds:
  - state encodings (IDLE/RD/WR/FIN)
  - mode constants (MODE_COPY=0, MODE_FILL=1)
  - MEM_DEPTH=128
- One sub-module, dmem_addr_seq: holds the start index, steps +/-1 modulo 2^ADDR_W on an enable, and is instantiated twice (src and dst).
- The FSM stays in the top module.

Test Plan:
- Fill: start, mode=1, dst=10, length=4, fill_value=0xA5A5A5A5:
  - words 10..13 = 0xA5A5A5A5, word 14 unchanged.
  - mem_write high exactly 4 consecutive cycles.
  - done pulses one cycle later.
- Non-overlapping copy: preload 20..22 = 1,2,3; copy src=20, dst=40, length=3:
  - 40..42 = 1,2,3.
  - mem_read/mem_write alternate, 6 access cycles.
- Overlapping forward copy: preload 0..3 = 1,2,3,4; copy src=0, dst=1, length=4:
  - descending order, and 1..4 = 1,2,3,4.
- Wrap-around fill: dst=126, length=4, fill_value=7:
  - words 126, 127, 0, 1 = 7, and word 2 unchanged.
- Boundary commands:
  - length=0 -> done pulse, zero memory accesses.
  - length=129 -> err pulse, busy stays 0, memory unchanged.
  - start while busy -> ignored.
- Reset mid-fill: fill dst=50, length=8; drop rst_n after 3 writes:
  - all outputs 0 immediately.
  - words 50..52 written, 53..57 unchanged, no done pulse.
